imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader directly upstream of the pipelined RISC-V cpu.
//  - Accepts a byte stream (valid/ready) carrying a word-count header plus instruction words.
//  - Writes the words into instruction memory through the cpu external port (addr_ext/wen_ext/wdata_ext).
//  - Raises cpu_enable once the load completes cleanly, so execution starts from BASE_ADDR.
// PARAMETERS
//  ADDR_W     9   instruction memory word-index width; capacity MAX_WORDS = 2**ADDR_W
//  CNT_W      16  width of header word count and words_loaded
//  BASE_ADDR  0   64-bit byte address of the first loaded word
// PORTS
//  clk          in   1      main clock
//  arst         in   1      reset; asynchronous, active-high
//  start        in   1      1-cycle pulse; begins a load (honoured in IDLE, DONE, ERROR)
//  s_valid      in   1      stream byte valid
//  s_data       in   8      stream byte
//  s_ready      out  1      loader accepts a byte this cycle
//  addr_ext     out  64     byte address to instruction memory ext port
//  wen_ext      out  1      ext write enable, 1-cycle pulse per word
//  ren_ext      out  1      ext read enable (verify only, else 0)
//  wdata_ext    out  32     word to write
//  rdata_ext    in   32     ext read data, valid 1 cycle after ren_ext
//  cpu_enable   out  1      drives cpu enable; 1 only in DONE
//  busy         out  1      1 in any state except IDLE/DONE/ERROR
//  done         out  1      1 in DONE
//  error        out  1      1 in ERROR
//  words_loaded out  CNT_W  words written in the current/last load
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is asynchronous and active-high (arst).
//  - Reset: state IDLE; all outputs 0; byte/word counters and checksum 0.
//    - Reset mid-load aborts immediately; already-written memory words are not cleared.
//  - States: IDLE, HDR, DATA, WRITE, [VRD, VCMP], DONE, ERROR.
//  - IDLE --start--> HDR. start in DONE/ERROR also -> HDR.
//    - On restart, cpu_enable drops in the same edge; counters and checksum clear.
//  - Byte handshake: a byte transfers on s_valid && s_ready.
//    - s_ready = 1 only in HDR and DATA; s_valid gaps stall without side effects.
//  - HDR: 2 bytes, little-endian -> count N (upper CNT_W-16 bits zero).
//    - N == 0 -> DONE.
//    - N > MAX_WORDS -> ERROR (no memory writes).
//    - Otherwise -> DATA.
//  - DATA: assemble 4 bytes little-endian (first byte = bits[7:0]); on 4th byte -> WRITE.
//  - WRITE (exactly 1 cycle):
//    - wen_ext=1, addr_ext = BASE_ADDR + 4*idx, wdata_ext = assembled word.
//    - Checksum ^= word; idx++; words_loaded = idx.
//    - If idx == N -> DONE (or VRD with verify), else -> DATA.
//  - Address arithmetic is 64-bit unsigned; idx < MAX_WORDS is guaranteed by the header check.
//  - Latency: last byte accepted -> wen_ext next cycle -> done/cpu_enable the cycle after.
//  - wen_ext and ren_ext are never asserted together; both 0 outside WRITE/VRD.
//  - addr_ext/wdata_ext hold their last value when unused.
//  - start while busy is ignored.
// CONFIGURATION
//  IMEM_LOADER_VERIFY_EN defined:
//    - After the last WRITE: VRD (ren_ext=1, addr of word j) -> VCMP (XOR rdata_ext into rchk), for j = 0..N-1.
//    - After word N-1: rchk == wchk -> DONE, else -> ERROR.
//    - Adds 2N cycles of latency.
//  IMEM_LOADER_VERIFY_EN undefined:
//    - No VRD/VCMP states; ren_ext tied 0.
// TESTING
//  1 start; bytes 02 00, 93 00 50 00, 13 01 10 00 -> wen@addr 0 data 00500093, wen@addr 4 data 00100113; done=1, cpu_enable=1, words_loaded=2
//  2 start; header 00 00 -> DONE 1 cycle after 2nd byte; no wen_ext; cpu_enable=1; words_loaded=0
//  3 ADDR_W=9, header 01 02 (513) -> error=1, cpu_enable=0, no wen_ext, s_ready=0
//  4 test 1 stream with s_valid toggled every other cycle -> identical writes/addresses, done later
//  5 arst pulse after first word written -> all outputs 0 async, state IDLE; restart with test 1 stream -> passes
//  6 VERIFY_EN, memory model flips bit0 of word 1 on readback -> ren_ext at addr 0 and 4, error=1, cpu_enable=0

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a counted program into cpu instruction memory.
// Optional readback check of the loaded image when IMEM_LOADER_VERIFY_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned CNT_W     = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
`ifdef IMEM_LOADER_VERIFY_EN
    ST_VRD,
    ST_VCMP,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d, idx_inc, loaded_d, hdr_n;
  logic [31:0]       wchk_q, wchk_d, wdata_d;
  logic [63:0]       addr_d;
  logic              wen_d, s_ready_d, busy_d, done_d, error_d, xfer;
`ifdef IMEM_LOADER_VERIFY_EN
  logic [31:0]       rchk_q, rchk_d;
  logic              ren_d;
`else
  logic              unused_rdata;
  assign unused_rdata = ^rdata_ext;
  assign ren_ext      = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wchk_d   = wchk_q;
    addr_d   = addr_ext;
    wdata_d  = wdata_ext;
    loaded_d = words_loaded;
    wen_d    = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
    rchk_d   = rchk_q;
    ren_d    = 1'b0;
`endif
    xfer     = s_valid && s_ready;
    shifted  = {s_data, word_q[31:8]};
    hdr_n    = CNT_W'(shifted[31:16]);
    idx_inc  = idx_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_HDR;
          byte_d   = '0;
          cnt_d    = '0;
          idx_d    = '0;
          wchk_d   = '0;
          loaded_d = '0;
`ifdef IMEM_LOADER_VERIFY_EN
          rchk_d   = '0;
`endif
        end
      end
      ST_HDR: begin
        if (xfer) begin
          word_d = shifted;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd1) begin
            byte_d = '0;
            cnt_d  = hdr_n;
            if (shifted[31:16] == 16'd0)
              state_d = ST_DONE;
            else if ({16'd0, shifted[31:16]} > 32'(MAX_WORDS))
              state_d = ST_ERROR;
            else
              state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          word_d = shifted;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d = ST_WRITE;
            wen_d   = 1'b1;
            addr_d  = BASE_ADDR + (64'(idx_q) << 2);
            wdata_d = shifted;
          end
        end
      end
      ST_WRITE: begin
        wchk_d   = wchk_q ^ wdata_ext;
        idx_d    = idx_inc;
        loaded_d = idx_inc;
        if (idx_inc == cnt_q) begin
`ifdef IMEM_LOADER_VERIFY_EN
          state_d = ST_VRD;
          idx_d   = '0;
          ren_d   = 1'b1;
          addr_d  = BASE_ADDR;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      ST_VRD: state_d = ST_VCMP;
      // Read data for word idx_q arrives in this cycle.
      ST_VCMP: begin
        rchk_d = rchk_q ^ rdata_ext;
        idx_d  = idx_inc;
        if (idx_inc == cnt_q) begin
          state_d = (rchk_d == wchk_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = ST_VRD;
          ren_d   = 1'b1;
          addr_d  = BASE_ADDR + (64'(idx_inc) << 2);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
    busy_d    = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wchk_q       <= '0;
      s_ready      <= 1'b0;
      addr_ext     <= '0;
      wen_ext      <= 1'b0;
      wdata_ext    <= '0;
      cpu_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
      rchk_q       <= '0;
      ren_ext      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wchk_q       <= wchk_d;
      s_ready      <= s_ready_d;
      addr_ext     <= addr_d;
      wen_ext      <= wen_d;
      wdata_ext    <= wdata_d;
      cpu_enable   <= done_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= loaded_d;
`ifdef IMEM_LOADER_VERIFY_EN
      rchk_q       <= rchk_d;
      ren_ext      <= ren_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load streams plus multi-cycle corner sequences.
module tb_imem_loader;

  logic        clk, arst, start, s_valid, s_ready, wen_ext, ren_ext;
  logic [7:0]  s_data;
  logic [63:0] addr_ext;
  logic [31:0] wdata_ext, rdata_ext;
  logic        cpu_enable, busy, done, error;
  logic [15:0] words_loaded;

  imem_loader dut (
    .clk(clk), .arst(arst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .cpu_enable(cpu_enable),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [13:0][7:0] b;
    logic [7:0]       nb;
    logic             gap;
    logic [7:0]       nw;
    logic [2:0][31:0] w;
    logic             exp_done;
    logic             exp_err;
    logic [15:0]      exp_wl;
  } vec_t;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t        vt [0:4];
  wr_t         sb [$];
  logic [63:0] ren_addrs [$];
  logic [31:0] mem [0:511];
  int          n_cmp = 0, n_bad = 0, wen_cnt = 0, n_ren = 0;
  bit          flip_w1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction memory model; optionally corrupts word 1 on readback.
  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^ ((flip_w1 && addr_ext[10:2] == 9'd1) ? 32'h1 : 32'h0);
  end

  // Scoreboard consumer: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!arst) begin
      if (wen_ext) begin
        wen_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_write", addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", addr_ext, e.a);
          check("wr_data", 64'(wdata_ext), 64'(e.d));
        end
      end
      if (ren_ext) begin
        n_ren++;
        ren_addrs.push_back(addr_ext);
      end
      if (wen_ext && ren_ext) check("wen_ren_overlap", 64'(1), 64'(0));
    end
  end

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    s_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    s_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic push_word(input int k, input logic [31:0] d);
    wr_t e;
    e.a = 64'(4 * k);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 5000; t++) begin
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    wen_cnt = 0;
    do_start();
    check({nm, "_busy_after_start"}, 64'(busy), 64'(1));
    check({nm, "_cpu_en_after_start"}, 64'(cpu_enable), 64'(0));
    for (int i = 0; i < int'(v.nb); i++) begin
      if (i >= 2 && ((i - 2) % 4) == 3) push_word((i - 2) / 4, v.w[(i - 2) / 4]);
      if (v.gap) idle_cycle();
      send_byte(v.b[i]);
    end
    wait_idle();
    @(posedge clk); #1;
    check({nm, "_done"}, 64'(done), 64'(v.exp_done));
    check({nm, "_error"}, 64'(error), 64'(v.exp_err));
    check({nm, "_cpu_enable"}, 64'(cpu_enable), 64'(v.exp_done));
    check({nm, "_words_loaded"}, 64'(words_loaded), 64'(v.exp_wl));
    check({nm, "_wen_count"}, 64'(wen_cnt), 64'(v.nw));
    check({nm, "_sb_empty"}, 64'(sb.size()), 64'(0));
    check({nm, "_s_ready"}, 64'(s_ready), 64'(0));
    sb.delete();
  endtask

  initial begin
    vt[0] = '0;
    vt[0].b = 112'({32'h00100113, 32'h00500093, 16'h0002});
    vt[0].nb = 8'd10; vt[0].nw = 8'd2;
    vt[0].w = 96'({32'h00100113, 32'h00500093});
    vt[0].exp_done = 1'b1; vt[0].exp_wl = 16'd2;
    vt[1] = '0;
    vt[1].nb = 8'd2; vt[1].exp_done = 1'b1;
    vt[2] = '0;
    vt[2].b = 112'(16'h0201);
    vt[2].nb = 8'd2; vt[2].exp_err = 1'b1;
    vt[3] = vt[0];
    vt[3].gap = 1'b1;
    vt[4] = '0;
    vt[4].b = 112'({32'h80000001, 32'h12345678, 32'hdeadbeef, 16'h0003});
    vt[4].nb = 8'd14; vt[4].nw = 8'd3;
    vt[4].w = {32'h80000001, 32'h12345678, 32'hdeadbeef};
    vt[4].exp_done = 1'b1; vt[4].exp_wl = 16'd3;

    arst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    #12;
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_cpu_enable", 64'(cpu_enable), 64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    arst = 1'b0;
    @(posedge clk); #1;

    run_vec(vt[0], "t1_basic");
    run_vec(vt[1], "t2_zero");
    run_vec(vt[2], "t3_oversize");
    run_vec(vt[3], "t4_gapped");
    run_vec(vt[4], "t_three_words");

    // Write-then-done latency, and zero-count done latency.
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
    push_word(0, 32'h00500093);
    send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h10);
    push_word(1, 32'h00100113);
    send_byte(8'h00);
    check("lat_wen_after_last", 64'(wen_ext), 64'(1));
    check("lat_done_not_yet", 64'(done), 64'(0));
`ifndef IMEM_LOADER_VERIFY_EN
    @(posedge clk); #1;
    check("lat_done", 64'(done), 64'(1));
    check("lat_cpu_enable", 64'(cpu_enable), 64'(1));
    check("lat_wen_drop", 64'(wen_ext), 64'(0));
`endif
    wait_idle();
    do_start();
    check("restart_cpu_enable_drop", 64'(cpu_enable), 64'(0));
    send_byte(8'h00); send_byte(8'h00);
    check("zero_done_next_cycle", 64'(done), 64'(1));
    check("zero_cpu_enable", 64'(cpu_enable), 64'(1));

    // Asynchronous reset after the first word is written.
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
    push_word(0, 32'h00500093);
    send_byte(8'h00);
    @(posedge clk); #1;
    check("pre_rst_words_loaded", 64'(words_loaded), 64'(1));
    #2 arst = 1'b1;
    #1;
    check("arst_addr", addr_ext, 64'(0));
    check("arst_wdata", 64'(wdata_ext), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_s_ready", 64'(s_ready), 64'(0));
    check("arst_words_loaded", 64'(words_loaded), 64'(0));
    check("arst_flags", 64'({wen_ext, ren_ext, cpu_enable, done, error}), 64'(0));
    #3 arst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    run_vec(vt[0], "t5_after_reset");

    // Full-capacity load; a start pulse mid-load must be ignored.
    wen_cnt = 0;
    do_start();
    send_byte(8'h00); send_byte(8'h02);
    for (int k = 0; k < 512; k++) begin
      logic [31:0] w;
      w = $urandom;
      if (k == 100) begin
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
        check("start_while_busy", 64'({busy, s_ready}), 64'(2'b11));
      end
      send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]);
      push_word(k, w);
      send_byte(w[31:24]);
    end
    wait_idle();
    check("full_done", 64'(done), 64'(1));
    check("full_words_loaded", 64'(words_loaded), 64'(512));
    check("full_wen_count", 64'(wen_cnt), 64'(512));
    check("full_sb_empty", 64'(sb.size()), 64'(0));

`ifdef IMEM_LOADER_VERIFY_EN
    // Readback corruption of word 1 must end in error.
    flip_w1 = 1'b1;
    ren_addrs.delete();
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
    push_word(0, 32'h00500093);
    send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h10);
    push_word(1, 32'h00100113);
    send_byte(8'h00);
    wait_idle();
    check("vfy_error", 64'(error), 64'(1));
    check("vfy_cpu_enable", 64'(cpu_enable), 64'(0));
    check("vfy_ren_count", 64'(ren_addrs.size()), 64'(2));
    if (ren_addrs.size() == 2) begin
      check("vfy_ren_addr0", ren_addrs[0], 64'(0));
      check("vfy_ren_addr1", ren_addrs[1], 64'(4));
    end
    flip_w1 = 1'b0;
`else
    check("ren_never_asserted", 64'(n_ren), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
